// File: rtl/dec_pkg.sv
// Shared types for the priority-code decoder.
// Holds the code word layout, FIFO state enum and default depth.
package dec_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic       active;
    logic [2:0] idx;
  } code_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_t;

endpackage

// File: rtl/code_fifo.sv
// In-order code FIFO with an EMPTY/PARTIAL/FULL control state.
// Ports: clk, reset, i_push/i_data, i_pop, o_data (head), o_state.
module code_fifo
  import dec_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  code_t       i_data,
  input  logic        i_pop,
  output code_t       o_data,
  output fifo_state_t o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LP_LAST = (AW+1)'(DEPTH - 1);

  code_t       r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;
  fifo_state_t r_state;

  logic w_push;
  logic w_pop;

  // Requests are masked so the FIFO never over/underflows on its own.
  assign w_push = i_push && (r_state != FULL);
  assign w_pop  = i_pop  && (r_state != EMPTY);

  assign o_data  = r_mem[r_rp];
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_state <= EMPTY;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      unique case (r_state)
        EMPTY: begin
          if (w_push) r_state <= PARTIAL;
        end
        PARTIAL: begin
          if (w_push && !w_pop && r_cnt == LP_LAST)
            r_state <= FULL;
          else if (w_pop && !w_push && r_cnt == LP_ONE)
            r_state <= EMPTY;
        end
        FULL: begin
          if (w_pop) r_state <= PARTIAL;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/prio_code_decoder.sv
// Buffers priority-encoder codes and decodes them to one-hot lines.
// Ports: in_* valid/ready input, out_* valid/ready output, decode_count.
module prio_code_decoder
  import dec_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_onehot,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_none,
  output logic [7:0] decode_count
);

  code_t       w_in;
  code_t       w_head;
  fifo_state_t w_state;
  logic        w_push;
  logic        w_load;
  logic [7:0]  w_onehot;

  logic        r_valid;
  logic [7:0]  r_onehot;
  logic        r_none;
  logic [7:0]  r_count;

  assign w_in     = in_code;
  assign in_ready = (w_state != FULL);
  assign w_push   = in_valid && in_ready;
  // Output register refills when empty or draining this cycle.
  assign w_load   = (w_state != EMPTY) && (!r_valid || out_ready);
  assign w_onehot = w_head.active ? (8'b1 << w_head.idx) : 8'h00;

  code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_state (w_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_onehot <= 8'h00;
      r_none   <= 1'b0;
      r_count  <= 8'h00;
    end else begin
      if (w_load) begin
        r_valid  <= 1'b1;
        r_onehot <= w_onehot;
        r_none   <= !w_head.active;
      end else if (out_ready) begin
        r_valid  <= 1'b0;
      end
      if (r_valid && out_ready && r_count != 8'hFF)
        r_count <= r_count + 8'd1;
    end
  end

  assign out_valid    = r_valid;
  assign out_onehot   = r_onehot;
  assign out_none     = r_none;
  assign decode_count = r_count;

endmodule
